// File: rtl/pu_accum_driver.sv
// rtl/pu_accum_driver.sv - microprogram sequencer driving one pu_accum instance and capturing its output
module pu_accum_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int OE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [4:0]            prog_word,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_data,
    input  logic [ATTR_WIDTH-1:0] op_attr,
    output logic                  signal_load,
    output logic                  signal_init,
    output logic                  signal_neg,
    output logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] acc_data_out,
    output logic [ATTR_WIDTH-1:0] acc_attr_out,
    input  logic [DATA_WIDTH-1:0] acc_data_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PC = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [4:0]              prog_mem [DEPTH];
    logic [4:0]              word;
    logic                    w_stop;
    logic                    w_oe;
    logic                    w_neg;
    logic                    w_init;
    logic                    w_load;
    logic                    stall;
    logic [OE_LATENCY-1:0]   oe_pipe;
    logic                    capture;

    assign word     = prog_mem[pc];
    assign w_stop   = word[4];
    assign w_oe     = word[3];
    assign w_neg    = word[2];
    assign w_init   = word[1];
    assign w_load   = word[0];
    assign op_ready = (state == S_RUN) && w_load;
    assign stall    = w_load && !op_valid;
    assign capture  = oe_pipe[OE_LATENCY-1];

    // Program memory survives reset; it can only be rewritten while idle.
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            prog_mem[prog_addr] <= prog_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            signal_load  <= 1'b0;
            signal_init  <= 1'b0;
            signal_neg   <= 1'b0;
            signal_oe    <= 1'b0;
            acc_data_out <= '0;
            acc_attr_out <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            oe_pipe      <= '0;
        end else begin
            signal_load  <= 1'b0;
            signal_init  <= 1'b0;
            signal_neg   <= 1'b0;
            signal_oe    <= 1'b0;
            acc_data_out <= '0;
            acc_attr_out <= '0;
            done         <= 1'b0;
            result_valid <= 1'b0;

            // oe_pipe[k] is signal_oe delayed by k+1 cycles; the last stage lines up with valid acc_data_in.
            oe_pipe[0] <= signal_oe;
            for (int i = 1; i < OE_LATENCY; i++) begin
                oe_pipe[i] <= oe_pipe[i-1];
            end

            if (capture) begin
                result       <= acc_data_in;
                result_valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        signal_load <= w_load;
                        signal_init <= w_init;
                        signal_neg  <= w_neg;
                        signal_oe   <= w_oe;
                        if (w_load) begin
                            acc_data_out <= op_data;
                            acc_attr_out <= op_attr;
                        end
                        if (w_stop || pc == LAST_PC) begin
                            state <= S_DRAIN;
                        end else begin
                            pc <= pc + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!signal_oe && oe_pipe == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_accum_driver.sv
// tb/tb_pu_accum_driver.sv - scoreboard bench for pu_accum_driver with a behavioural accumulator
module tb_pu_accum_driver;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int PW = 4;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_we = 1'b0;
    logic [PW-1:0] prog_addr = '0;
    logic [4:0]    prog_word = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [DW-1:0] op_data = '0;
    logic [AW-1:0] op_attr = '0;
    logic          signal_load;
    logic          signal_init;
    logic          signal_neg;
    logic          signal_oe;
    logic [DW-1:0] acc_data_out;
    logic [AW-1:0] acc_attr_out;
    logic [DW-1:0] acc_data_in = '0;
    logic [DW-1:0] result;
    logic          result_valid;

    pu_accum_driver #(
        .DATA_WIDTH(DW),
        .ATTR_WIDTH(AW),
        .ADDR_WIDTH(PW),
        .OE_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_word(prog_word),
        .start(start), .busy(busy), .done(done),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_attr(op_attr),
        .signal_load(signal_load), .signal_init(signal_init),
        .signal_neg(signal_neg), .signal_oe(signal_oe),
        .acc_data_out(acc_data_out), .acc_attr_out(acc_attr_out),
        .acc_data_in(acc_data_in),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW+AW-1:0] exp_ops[$];
    logic [DW-1:0]    exp_res[$];
    logic [4:0]       prog_model [16];
    logic [4:0]       pw [16];
    logic [DW+AW-1:0] ops [16];
    int               gaps [16];
    logic [DW-1:0]    acc_ref = '0;
    int               exp_loads;
    int               load_cnt;
    int               idx = 0;
    int               gap_cnt = 0;
    int               stall_cnt = 0;
    bit               hs = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Environment model of pu_accum: load adds (or negates / initialises); oe reads the updated sum.
    logic [DW-1:0] acc = '0;
    logic [DW-1:0] acc_n;
    logic [DW-1:0] acc_v;
    always @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            acc_data_in <= '0;
        end else begin
            acc_n = acc;
            if (signal_load) begin
                acc_v = signal_neg ? -acc_data_out : acc_data_out;
                acc_n = signal_init ? acc_v : acc + acc_v;
            end
            acc <= acc_n;
            if (signal_oe) acc_data_in <= acc_n;
        end
    end

    // Operand source with per-operand idle gaps.
    always @(negedge clk) begin
        if (hs) begin
            idx++;
            gap_cnt = (idx < 16) ? gaps[idx] : 0;
        end
        if (gap_cnt > 0) begin
            op_valid = 1'b0;
            gap_cnt--;
        end else begin
            op_valid = (idx < 16);
        end
        {op_attr, op_data} = (idx < 16) ? ops[idx] : '0;
        #1;
        hs = op_valid && op_ready && !rst;
        if (op_ready && !op_valid && !rst) stall_cnt++;
    end

    // Monitor: pops the scoreboard whenever the DUT presents an operand or a result.
    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_res.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL result: got %0h expected none", result);
            end else begin
                check("result", 64'(result), 64'(exp_res.pop_front()));
            end
        end
        if (signal_load) begin
            load_cnt++;
            if (exp_ops.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL operand: got %0h expected none", {acc_attr_out, acc_data_out});
            end else begin
                check("operand", 64'({acc_attr_out, acc_data_out}), 64'(exp_ops.pop_front()));
            end
        end else begin
            if (acc_data_out != '0 || acc_attr_out != '0) begin
                n_cmp++; n_err++;
                $display("FAIL idle_data: got %0h expected 0", {acc_attr_out, acc_data_out});
            end
        end
    end

    // Reference: walk the program from address 0, stop on a stop bit or the last address.
    task automatic predict();
        int k = 0;
        logic [4:0] w;
        logic [DW-1:0] d, v;
        exp_loads = 0;
        for (int p = 0; p < 16; p++) begin
            w = prog_model[p];
            if (w[0]) begin
                d = ops[k][DW-1:0];
                exp_ops.push_back(ops[k]);
                k++;
                exp_loads++;
                v = w[2] ? -d : d;
                acc_ref = w[1] ? v : acc_ref + v;
            end
            if (w[3]) exp_res.push_back(acc_ref);
            if (w[4]) break;
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = PW'(i); prog_word = pw[i];
            prog_model[i] = pw[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, 64'({busy, done, op_ready, signal_load, signal_init, signal_neg,
                                   signal_oe, result_valid}), 64'(0));
        check({name, "_data"}, 64'({acc_attr_out, acc_data_out}), 64'(0));
        check({name, "_result"}, 64'(result), 64'(0));
    endtask

    task automatic do_run(input int max_gap, input bit fixed_ops, input bit gap1,
                          input bit wr_en, input logic [PW-1:0] wr_addr, input logic [4:0] wr_word,
                          input bit disturb, input bit rst_mid);
        int cyc;
        bit seen_done;
        @(negedge clk);
        #2;
        if (wr_en) prog_model[wr_addr] = wr_word;
        for (int i = 0; i < 16; i++) begin
            ops[i]  = {AW'($urandom), DW'($urandom)};
            gaps[i] = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        end
        if (fixed_ops) begin
            ops[0][DW-1:0] = DW'(5);
            ops[1][DW-1:0] = DW'(3);
        end
        if (gap1) gaps[1] = 3;
        predict();
        idx = 0; hs = 1'b0; gap_cnt = gaps[0]; stall_cnt = 0; load_cnt = 0;
        @(negedge clk);
        start = 1'b1; prog_we = wr_en; prog_addr = wr_addr; prog_word = wr_word;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        if (rst_mid) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_zero("rst_mid");
            exp_res.delete();
            exp_ops.delete();
            acc_ref = '0;
            seen_done = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (done) seen_done = 1'b1;
            end
            check("no_done_after_rst", 64'(seen_done), 64'(0));
            return;
        end
        if (disturb) begin
            @(negedge clk);
            start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_word = 5'h1f;
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
            exp_res.delete();
            exp_ops.delete();
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            acc_ref = '0;
        end else begin
            #2;
            check("results_pending", 64'(exp_res.size()), 64'(0));
            check("load_count", 64'(load_cnt), 64'(exp_loads));
            @(negedge clk);
            check("idle_after_done", 64'({busy, done}), 64'(0));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // basic accumulate: 5 + 3
        for (int i = 0; i < 16; i++) pw[i] = 5'b00000;
        pw[0] = 5'b00011; pw[1] = 5'b00001; pw[2] = 5'b11000;
        load_prog();
        do_run(0, 1, 0, 0, '0, '0, 0, 0);
        check("t1_result", 64'(result), 64'(8));

        // negate second operand, program word written together with start
        do_run(0, 1, 0, 1, PW'(1), 5'b00101, 0, 0);
        check("t2_result", 64'(result), 64'(2));

        // operand stall of three cycles
        do_run(0, 1, 1, 1, PW'(1), 5'b00001, 0, 0);
        check("t3_stalls", 64'(stall_cnt), 64'(3));
        check("t3_result", 64'(result), 64'(8));

        // no stop bit: run must end after the last address
        pw[0] = 5'b00011;
        for (int i = 1; i < 15; i++) pw[i] = {1'b0, 1'($urandom), 2'b00, 1'($urandom)};
        pw[15] = 5'b01001;
        load_prog();
        do_run(2, 0, 0, 0, '0, '0, 0, 0);

        // reset in the middle of a run, then a clean rerun
        for (int i = 0; i < 16; i++) pw[i] = 5'b00000;
        pw[0] = 5'b00011; pw[1] = 5'b00001; pw[2] = 5'b11000;
        load_prog();
        do_run(0, 1, 0, 0, '0, '0, 0, 1);
        do_run(0, 1, 0, 0, '0, '0, 0, 0);
        check("t5_result", 64'(result), 64'(8));

        // start and program write while busy are ignored
        do_run(0, 1, 0, 0, '0, '0, 1, 0);
        check("t6_result", 64'(result), 64'(8));
        do_run(0, 1, 0, 0, '0, '0, 0, 0);
        check("t6_rerun", 64'(result), 64'(8));

        // random programs
        for (int r = 0; r < 10; r++) begin
            int len;
            len = int'($urandom_range(1, 16));
            for (int i = 0; i < 16; i++) begin
                pw[i] = {1'b0, 4'($urandom)};
                if (i == len - 1 && len < 16) pw[i][4] = 1'b1;
            end
            load_prog();
            do_run(3, 0, 0, 0, '0, '0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
